uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the UART path. It adds configurable data width, oversampling ratio, runtime parity (none/even/odd) and one or two stop bits, plus an input synchroniser. It reports parity error, framing error and break. It sits between the pad-side rx line and the rx FIFO/interface logic, and is driven by the shared baud-rate tick generator.

Parameters:
NB_DATA, 8, data bits per frame; legal 5..9.
OVERSAMPLE, 16, i_tick pulses per bit period; even, at least 8.
NB_SYNC, 2, synchroniser flops on i_rx; at least 2.

Ports:
i_clock  input  1  system clock, rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_rx  input  1  serial line, asynchronous; idles high.
i_tick  input  1  oversample enable; one-cycle pulse, OVERSAMPLE per bit.
i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
i_two_stop  input  1  1 = two stop bits are checked.
o_rx_data  output  NB_DATA  last received word, LSB = first bit on line.
o_rx_done  output  1  one-cycle pulse: frame complete, data and flags valid.
o_parity_err  output  1  parity mismatch on last frame.
o_frame_err  output  1  a stop bit sampled low on last frame.
o_break  output  1  last frame was a break: all data, parity and first stop samples low.

Behaviour:
- Reset is asynchronous: all registers clear immediately, state = IDLE, all outputs 0, synchroniser flops set to 1. Reset mid-frame aborts the frame and produces no o_rx_done.
- i_rx passes through an NB_SYNC-flop synchroniser (rx_s). All logic uses rx_s only, so there is NB_SYNC cycles of input latency.
- Tick counter width is clog2(OVERSAMPLE). It is cleared on every state entry and advances only on i_tick.
- States:
  - IDLE: when rx_s = 0, latch i_parity_mode and i_two_stop, clear counters, go to START. Mode inputs are ignored for the rest of the frame.
  - START: on the i_tick where count = OVERSAMPLE/2-1: if rx_s = 0, go to DATA and clear the tick and bit counters; else return to IDLE (glitch rejected, no flags change).
  - DATA: on the i_tick where count = OVERSAMPLE-1, shift rx_s in at the MSB and shift right, then increment the bit counter. After bit NB_DATA-1, go to PARITY if the latched mode is even or odd, else go to STOP1.
  - PARITY: sample at count = OVERSAMPLE-1 and store the parity bit, then go to STOP1.
  - STOP1: sample at count = OVERSAMPLE-1. If i_two_stop is latched and the sample is 1, go to STOP2; otherwise the frame ends.
  - STOP2: sample at count = OVERSAMPLE-1; the frame ends.
  - LINE_WAIT: entered when the frame ended with any stop sample = 0. Stays until rx_s = 1, then IDLE. No new start is detected while the line is held low.
- Frame end, edge N+1 after the final stop sample cycle N:
  - o_rx_done = 1 for exactly one cycle.
  - o_rx_data, o_parity_err, o_frame_err and o_break all update on the same edge and hold until the next o_rx_done.
- Parity error:
  - even: ^data ^ parity_bit ≠ 0.
  - odd: ^data ^ parity_bit ≠ 1.
  - none: always 0.
- o_frame_err = any checked stop sample was 0.
- o_break = data = 0, parity sample (if any) = 0 and STOP1 sample = 0. Break implies o_frame_err = 1.
- The receiver never stalls: there is no ready input. The downstream block must consume on o_rx_done.
- i_tick held high continuously is legal: counting proceeds every cycle.
- Sample points are spaced exactly OVERSAMPLE ticks after the mid-start sample.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the state encoding (one-hot, 7 states);
  - the default OVERSAMPLE.
- One sub-module, uart_rx_sync: an NB_SYNC-flop synchroniser with reset value 1, reusable by other async inputs.
- Everything else is flat in uart_rx_cfg, using separate state, next-state and output-register processes.

Test Plan:
1. Config NB_DATA=8, OVERSAMPLE=16, mode none, one stop; send 0xA5 -> one o_rx_done pulse, o_rx_data=0xA5, all error flags 0, done arrives about 9.5 bit periods after the falling edge plus 2 sync cycles.
2. Even parity, send 0x37 (five ones) with parity bit 1 -> data 0x37, parity_err=0. Repeat with parity bit 0 -> parity_err=1. Odd mode with 0x37 and parity 0 -> parity_err=0.
3. Two stop bits, send 0x5A with second stop driven 0 -> done, data 0x5A, frame_err=1. Receiver stays in LINE_WAIT until the line returns high; a following 0x3C frame is then received cleanly.
4. Line held low for 2 full frames -> single done with data 0x00, frame_err=1, break=1. No further done until the line returns high, then a normal frame is received.
5. Low glitch of 4 ticks on an idle line -> no o_rx_done, receiver back in IDLE, a subsequent 0xFF frame is received correctly.
6. Assert i_reset for 1 cycle during DATA bit 3 -> outputs 0 immediately, no done for the aborted frame. Next full frame 0x81 is received, and also with NB_DATA=5, where 0x15 is received as 0x15.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, default oversampling.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [6:0] {
        S_IDLE      = 7'b000_0001,
        S_START     = 7'b000_0010,
        S_DATA      = 7'b000_0100,
        S_PARITY    = 7'b000_1000,
        S_STOP1     = 7'b001_0000,
        S_STOP2     = 7'b010_0000,
        S_LINE_WAIT = 7'b100_0000
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 1 (idle line).
module uart_rx_sync #(
    parameter int NB_SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [NB_SYNC-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[NB_SYNC-2:0], din};
        end
    end

    assign dout = sync_q[NB_SYNC-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: NB_DATA bits, runtime parity, 1/2 stop bits, break detect.
// Results are registered one cycle after the final stop sample; there is no backpressure.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int NB_SYNC    = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tick,
    input  logic [1:0]         i_parity_mode,
    input  logic               i_two_stop,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);

    logic               rx_s;
    rx_state_t          state, state_next;
    logic [CW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic               par_en, par_odd, two_stop_q, par_bit;
    logic               sample, mid_sample, last_bit;
    logic               frame_end, frame_bad, brk;

    uart_rx_sync #(.NB_SYNC(NB_SYNC)) u_sync (
        .clock (i_clock),
        .reset (i_reset),
        .din   (i_rx),
        .dout  (rx_s)
    );

    assign sample     = i_tick && (tick_cnt == CW'(OVERSAMPLE - 1));
    assign mid_sample = i_tick && (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
    assign last_bit   = (bit_cnt == BW'(NB_DATA - 1));
    // A break can only finish in STOP1: a high STOP1 sample already rules it out.
    assign brk        = (state == S_STOP1) && !rx_s && (shreg == '0) && !(par_en && par_bit);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (mid_sample) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample && last_bit) state_next = par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (sample) state_next = S_STOP1;
            end
            S_STOP1: begin
                if (sample) begin
                    if (two_stop_q && rx_s) begin
                        state_next = S_STOP2;
                    end else begin
                        frame_end  = 1'b1;
                        frame_bad  = !rx_s;
                        state_next = rx_s ? S_IDLE : S_LINE_WAIT;
                    end
                end
            end
            S_STOP2: begin
                if (sample) begin
                    frame_end  = 1'b1;
                    frame_bad  = !rx_s;
                    state_next = rx_s ? S_IDLE : S_LINE_WAIT;
                end
            end
            S_LINE_WAIT: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            if (state_next != state) begin
                tick_cnt <= '0;
            end else if (i_tick) begin
                tick_cnt <= (tick_cnt == CW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + CW'(1);
            end

            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            // Mode is frozen at the start edge so mid-frame changes cannot corrupt a frame.
            if (state == S_IDLE && !rx_s) begin
                par_en     <= (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
                par_odd    <= (i_parity_mode == PAR_ODD);
                two_stop_q <= i_two_stop;
                par_bit    <= 1'b0;
            end

            if (state == S_DATA && sample) begin
                shreg <= {rx_s, shreg[NB_DATA-1:1]};
            end

            if (state == S_PARITY && sample) begin
                par_bit <= rx_s;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rx_done    <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_rx_done <= frame_end;
            if (frame_end) begin
                o_rx_data    <= shreg;
                o_parity_err <= par_en && ((^shreg) ^ par_bit ^ par_odd);
                o_frame_err  <= frame_bad;
                o_break      <= brk;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8-bit instance ticked every 3 cycles and a 5-bit instance ticked continuously.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, tick_a, two_a;
    logic [1:0] pm_a;
    logic [7:0] data_a;
    logic       done_a, perr_a, ferr_a, brk_a;
    logic       rx_b, tick_b, two_b;
    logic [1:0] pm_b;
    logic [4:0] data_b;
    logic       done_b, perr_b, ferr_b, brk_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt_a = 0, done_cnt_b = 0, pushed_a = 0, pushed_b = 0;
    int   done_cyc_a = 0, fall_cyc = 0, n0 = 0, lat = 0;
    int   tdiv = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .NB_SYNC(2)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_rx(rx_a), .i_tick(tick_a),
        .i_parity_mode(pm_a), .i_two_stop(two_a), .o_rx_data(data_a),
        .o_rx_done(done_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a)
    );

    uart_rx_cfg #(.NB_DATA(5), .OVERSAMPLE(16), .NB_SYNC(3)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_rx(rx_b), .i_tick(tick_b),
        .i_parity_mode(pm_b), .i_two_stop(two_b), .o_rx_data(data_b),
        .o_rx_done(done_b), .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int nb, input logic [8:0] d, input logic [1:0] pm,
                                   input logic p, input bit two, input logic s1, input logic s2);
        exp_t       r;
        logic [8:0] m;
        logic       x, par_on;
        m      = d & ((9'h1 << nb) - 9'h1);
        par_on = (pm == PAR_EVEN) || (pm == PAR_ODD);
        x      = (^m) ^ p;
        r.d    = m;
        r.pe   = (pm == PAR_EVEN) ? x : (pm == PAR_ODD) ? ~x : 1'b0;
        r.fe   = !s1 || (two && !s2);
        r.bk   = (m == 9'h0) && !(par_on && p) && !s1;
        return r;
    endfunction

    initial begin
        tick_a = 1'b0;
        tick_b = 1'b1;
        forever begin
            @(negedge clk);
            tdiv   = (tdiv + 1) % 3;
            tick_a = (tdiv == 0);
        end
    end

    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            if (q_a.size() == 0) begin
                check("spurious_done_a", done_a, 0);
            end else begin
                ea = q_a.pop_front();
                check("data_a", data_a, ea.d);
                check("perr_a", perr_a, ea.pe);
                check("ferr_a", ferr_a, ea.fe);
                check("brk_a", brk_a, ea.bk);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            if (q_b.size() == 0) begin
                check("spurious_done_b", done_b, 0);
            end else begin
                eb = q_b.pop_front();
                check("data_b", data_b, eb.d);
                check("perr_b", perr_b, eb.pe);
                check("ferr_b", ferr_b, eb.fe);
                check("brk_b", brk_b, eb.bk);
            end
        end
    end

    task automatic drive(input bit b, input logic v, input int n);
        if (b) rx_b = v;
        else   rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit b, input int nb, input logic [8:0] d, input logic [1:0] pm,
                        input logic p, input bit two, input logic s1, input logic s2, input bit push);
        int bp;
        bp = b ? 16 : 48;
        if (push) begin
            if (b) begin q_b.push_back(model(nb, d, pm, p, two, s1, s2)); pushed_b++; end
            else   begin q_a.push_back(model(nb, d, pm, p, two, s1, s2)); pushed_a++; end
        end
        if (b) begin pm_b = pm; two_b = two; end
        else   begin pm_a = pm; two_a = two; end
        fall_cyc = cyc;
        drive(b, 1'b0, bp);
        // Disturb the mode inputs: the receiver must use the values latched at the start edge.
        if (b) begin pm_b = ~pm; two_b = ~two; end
        else   begin pm_a = ~pm; two_a = ~two; end
        for (int i = 0; i < nb; i++) drive(b, d[i], bp);
        if (pm == PAR_EVEN || pm == PAR_ODD) drive(b, p, bp);
        drive(b, s1, bp);
        if (two) drive(b, s2, bp);
    endtask

    task automatic idle(input bit b, input int nbits);
        drive(b, 1'b1, nbits * (b ? 16 : 48));
    endtask

    task automatic drain(input bit b, input string tag);
        for (int i = 0; i < 3000 && (b ? q_b.size() : q_a.size()) != 0; i++) @(negedge clk);
        check(tag, b ? q_b.size() : q_a.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        pm_a = PAR_NONE; pm_b = PAR_NONE; two_a = 1'b0; two_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_a", data_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_flags_a", {perr_a, ferr_a, brk_a}, 0);
        check("rst_data_b", data_b, 0);
        check("rst_flags_b", {done_b, perr_b, ferr_b, brk_b}, 0);
        rst = 1'b0;
        idle(0, 2);

        // Plain 8N1 frame and start-to-done latency
        send(0, 8, 9'h0A5, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 1);
        drain(0, "drain_t1");
        lat = done_cyc_a - fall_cyc;
        check("latency_t1", (lat >= 454 && lat <= 462), 1);
        idle(0, 2);

        // Parity: even good, even bad, odd good
        send(0, 8, 9'h037, PAR_EVEN, 1'b1, 0, 1'b1, 1'b1, 1); idle(0, 2);
        send(0, 8, 9'h037, PAR_EVEN, 1'b0, 0, 1'b1, 1'b1, 1); idle(0, 2);
        send(0, 8, 9'h037, PAR_ODD,  1'b0, 0, 1'b1, 1'b1, 1); idle(0, 2);
        drain(0, "drain_t2");

        // Two stop bits, second stop low, line held low afterwards
        n0 = done_cnt_a;
        send(0, 8, 9'h05A, PAR_NONE, 1'b0, 1, 1'b1, 1'b0, 1);
        drive(0, 1'b0, 3 * 48);
        check("line_wait_done_cnt", done_cnt_a - n0, 1);
        idle(0, 2);
        send(0, 8, 9'h03C, PAR_NONE, 1'b0, 1, 1'b1, 1'b1, 1); idle(0, 2);
        drain(0, "drain_t3");

        // Break: line low for two full frames
        n0 = done_cnt_a;
        pm_a = PAR_NONE; two_a = 1'b0;
        q_a.push_back(model(8, 9'h000, PAR_NONE, 1'b0, 0, 1'b0, 1'b0)); pushed_a++;
        drive(0, 1'b0, 22 * 48);
        check("break_done_cnt", done_cnt_a - n0, 1);
        idle(0, 2);
        send(0, 8, 9'h0C3, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 1); idle(0, 2);
        drain(0, "drain_t4");

        // Short low glitch on an idle line
        n0 = done_cnt_a;
        drive(0, 1'b0, 12);
        idle(0, 3);
        check("glitch_done_cnt", done_cnt_a - n0, 0);
        send(0, 8, 9'h0FF, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 1); idle(0, 2);
        drain(0, "drain_t5");

        // Reset pulse during data bit 3; remaining bits of this frame are high
        n0 = done_cnt_a;
        fork
            send(0, 8, 9'h0F8, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 0);
            begin
                repeat (4 * 48 + 24) @(negedge clk);
                #1 rst = 1'b1;
                #1;
                check("rst_mid_data_a", data_a, 0);
                check("rst_mid_flags_a", {done_a, perr_a, ferr_a, brk_a}, 0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(0, 2);
        check("abort_done_cnt", done_cnt_a - n0, 0);
        send(0, 8, 9'h081, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 1); idle(0, 2);
        drain(0, "drain_t6");

        // 5-bit instance with continuous tick
        idle(1, 2);
        send(1, 5, 9'h015, PAR_NONE, 1'b0, 0, 1'b1, 1'b1, 1); idle(1, 2);
        send(1, 5, 9'h00A, PAR_ODD,  1'b1, 0, 1'b1, 1'b1, 1); idle(1, 2);
        send(1, 5, 9'h01F, PAR_EVEN, 1'b0, 1, 1'b1, 1'b1, 1); idle(1, 2);
        send(1, 5, 9'h000, PAR_NONE, 1'b0, 0, 1'b0, 1'b1, 1); idle(1, 4);
        drain(1, "drain_b");

        check("done_cnt_a", done_cnt_a, pushed_a);
        check("done_cnt_b", done_cnt_b, pushed_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
